// File: rtl/tile_quad_shifter_if.sv
// Tile quad shifter bus: input beat (valid/ready, offsets, tile) and output
// beat (valid/ready, four quadrant images).
//   slave  : view used by tile_quad_shifter
//   master : view used by the producer/consumer side
// Optional macro TILE_QUAD_SHIFTER_WRAP_EN adds the 1-bit wrap input.
interface tile_quad_shifter_if #(
   parameter int unsigned TILE_W = 8,
   parameter int unsigned TILE_H = 8,
   parameter int unsigned BPP    = 2
);
   localparam int unsigned IMG_W = TILE_W * TILE_H * BPP;
   localparam int unsigned XW    = $clog2(TILE_W);
   localparam int unsigned YW    = $clog2(TILE_H);

   logic             in_valid;
   logic             in_ready;
   logic [XW-1:0]    offset_x;
   logic [YW-1:0]    offset_y;
   logic [IMG_W-1:0] img;
   logic             out_valid;
   logic             out_ready;
   logic [IMG_W-1:0] q0;
   logic [IMG_W-1:0] q1;
   logic [IMG_W-1:0] q2;
   logic [IMG_W-1:0] q3;
`ifdef TILE_QUAD_SHIFTER_WRAP_EN
   logic             wrap;

   modport slave (
      input  in_valid, offset_x, offset_y, img, wrap, out_ready,
      output in_ready, out_valid, q0, q1, q2, q3
   );
   modport master (
      output in_valid, offset_x, offset_y, img, wrap, out_ready,
      input  in_ready, out_valid, q0, q1, q2, q3
   );
`else
   modport slave (
      input  in_valid, offset_x, offset_y, img, out_ready,
      output in_ready, out_valid, q0, q1, q2, q3
   );
   modport master (
      output in_valid, offset_x, offset_y, img, out_ready,
      input  in_ready, out_valid, q0, q1, q2, q3
   );
`endif
endinterface

// File: rtl/tile_quad_shifter.sv
// tile_quad_shifter: shifts one TILE_W x TILE_H tile (BPP bits/pixel) by a
// sub-tile offset (ox,oy) and emits the home quadrant plus the right, below
// and diagonal spill quadrants. Two registered stages, valid/ready both sides.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   clk_en  global pipeline enable; low freezes all state and forces in_ready=0
//   bus     tile_quad_shifter_if.slave (in_valid/in_ready/offset_x/offset_y/img,
//           out_valid/out_ready/q0..q3)
// Optional macro TILE_QUAD_SHIFTER_WRAP_EN: adds bus.wrap; wrap=1 gives a
// toroidal scroll in q0 with q1..q3 = 0.
module tile_quad_shifter #(
   parameter int unsigned TILE_W = 8,
   parameter int unsigned TILE_H = 8,
   parameter int unsigned BPP    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_en,
   tile_quad_shifter_if.slave    bus
);
   localparam int unsigned IMG_W = TILE_W * TILE_H * BPP;
   localparam int unsigned YW    = $clog2(TILE_H);
   localparam int unsigned RW    = TILE_W * BPP;
   localparam int unsigned HSW   = $clog2(2 * RW) + 1;
   localparam int unsigned VSW   = $clog2(2 * IMG_W) + 1;

   logic             started;
   logic             s1_v;
   logic             s2_v;
   logic [IMG_W-1:0] s1_home;
   logic [IMG_W-1:0] s1_spill;
   logic [YW-1:0]    s1_oy;
   logic             s1_wrap;
   logic [IMG_W-1:0] q0_r, q1_r, q2_r, q3_r;

   logic             wrap_in_c;
   logic             s2_load_c;
   logic             s1_load_c;
   logic             accept_c;

`ifdef TILE_QUAD_SHIFTER_WRAP_EN
   assign wrap_in_c = bus.wrap;
`else
   assign wrap_in_c = 1'b0;
`endif

   // A stage loads when it is empty or its beat moves on this cycle.
   assign s2_load_c    = !s2_v || bus.out_ready;
   assign s1_load_c    = !s1_v || s2_load_c;
   // started delays in_ready to the first enabled edge after reset release.
   assign bus.in_ready = clk_en && started && s1_load_c;
   assign accept_c     = bus.in_valid && bus.in_ready;

   assign bus.out_valid = s2_v;
   assign bus.q0        = q0_r;
   assign bus.q1        = q1_r;
   assign bus.q2        = q2_r;
   assign bus.q3        = q3_r;

   // Stage 1 datapath: per-row left shift by ox pixels into a double-width
   // row; the low half is the home row, the high half the right spill.
   logic [IMG_W-1:0] h_home_c, h_spill_c;
   logic [2*RW-1:0]  row_ext_c;
   logic [HSW-1:0]   hsh_c;
   always_comb begin
      h_home_c  = '0;
      h_spill_c = '0;
      row_ext_c = '0;
      hsh_c     = HSW'(bus.offset_x) * HSW'(BPP);
      for (int y = 0; y < int'(TILE_H); y++) begin
         row_ext_c = {{RW{1'b0}}, bus.img[y*RW +: RW]} << hsh_c;
         h_home_c[y*RW +: RW]  = row_ext_c[RW-1:0];
         h_spill_c[y*RW +: RW] = row_ext_c[2*RW-1:RW];
      end
      // Wrap folds the spill back in, turning the shift into a rotate.
      if (wrap_in_c) begin
         h_home_c  = h_home_c | h_spill_c;
         h_spill_c = '0;
      end
   end

   // Stage 2 datapath: whole-image shift by oy rows; low half stays in the
   // home tile row range, high half spills into the tile below.
   logic [2*IMG_W-1:0] v_home_c, v_spill_c;
   logic [VSW-1:0]     vsh_c;
   logic [IMG_W-1:0]   q0_c, q1_c, q2_c, q3_c;
   always_comb begin
      vsh_c     = VSW'(s1_oy) * VSW'(RW);
      v_home_c  = {{IMG_W{1'b0}}, s1_home}  << vsh_c;
      v_spill_c = {{IMG_W{1'b0}}, s1_spill} << vsh_c;
      q0_c      = v_home_c[IMG_W-1:0];
      q1_c      = v_spill_c[IMG_W-1:0];
      q2_c      = v_home_c[2*IMG_W-1:IMG_W];
      q3_c      = v_spill_c[2*IMG_W-1:IMG_W];
      if (s1_wrap) begin
         q0_c = v_home_c[IMG_W-1:0] | v_home_c[2*IMG_W-1:IMG_W];
         q1_c = '0;
         q2_c = '0;
         q3_c = '0;
      end
   end

   // Pipeline registers; data only updates when a valid beat lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started  <= 1'b0;
         s1_v     <= 1'b0;
         s2_v     <= 1'b0;
         s1_home  <= '0;
         s1_spill <= '0;
         s1_oy    <= '0;
         s1_wrap  <= 1'b0;
         q0_r     <= '0;
         q1_r     <= '0;
         q2_r     <= '0;
         q3_r     <= '0;
      end else if (clk_en) begin
         started <= 1'b1;
         if (s1_load_c) begin
            s1_v <= accept_c;
            if (accept_c) begin
               s1_home  <= h_home_c;
               s1_spill <= h_spill_c;
               s1_oy    <= bus.offset_y;
               s1_wrap  <= wrap_in_c;
            end
         end
         if (s2_load_c) begin
            s2_v <= s1_v;
            if (s1_v) begin
               q0_r <= q0_c;
               q1_r <= q1_c;
               q2_r <= q2_c;
               q3_r <= q3_c;
            end
         end
      end
   end
endmodule

// File: tb/tb_tile_quad_shifter.sv
// Directed self-checking bench for tile_quad_shifter (8x8 tile, 2 bpp).
module tb_tile_quad_shifter;
   logic clk;
   logic rst_n;
   logic clk_en;

   int n_cmp = 0;
   int n_bad = 0;

   tile_quad_shifter_if #(.TILE_W(8), .TILE_H(8), .BPP(2)) bus ();

   tile_quad_shifter #(.TILE_W(8), .TILE_H(8), .BPP(2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] beat(input int i);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(i);
      return {w, w, w, w};
   endfunction

   // One beat through an empty pipeline with out_ready held high.
   task automatic single(input string tag, input logic [127:0] im,
                         input logic [2:0] ox, input logic [2:0] oy,
                         input logic [127:0] e0, input logic [127:0] e1,
                         input logic [127:0] e2, input logic [127:0] e3);
      clk_en        = 1'b1;
      bus.out_ready = 1'b1;
      bus.img       = im;
      bus.offset_x  = ox;
      bus.offset_y  = oy;
      bus.in_valid  = 1'b1;
      #1;
      check({tag, "_rdy"}, 128'(bus.in_ready), 128'(1));
      tick();
      bus.in_valid = 1'b0;
      check({tag, "_lat1"}, 128'(bus.out_valid), 128'(0));
      tick();
      check({tag, "_lat2"}, 128'(bus.out_valid), 128'(1));
      check({tag, "_q0"}, bus.q0, e0);
      check({tag, "_q1"}, bus.q1, e1);
      check({tag, "_q2"}, bus.q2, e2);
      check({tag, "_q3"}, bus.q3, e3);
      tick();
      check({tag, "_drain"}, 128'(bus.out_valid), 128'(0));
   endtask

   // Streams n beats (ox=oy=0 so q0 = img) with optional out_ready-low and
   // clk_en-low windows, given as inclusive cycle ranges (-1 = none).
   task automatic run_stream(input string tag, input int n,
                             input int rlo_a, input int rlo_b,
                             input int elo_a, input int elo_b,
                             input logic expect_block);
      logic [127:0] prev_q0;
      logic         prev_ov;
      logic         prev_en;
      logic         prev_stall;
      logic         saw_block;
      int           sent;
      int           recv;
      prev_q0 = '0; prev_ov = 1'b0; prev_en = 1'b1; prev_stall = 1'b0;
      saw_block = 1'b0; sent = 0; recv = 0;
      bus.offset_x = '0;
      bus.offset_y = '0;
      for (int cyc = 0; cyc < 60 && recv < n; cyc++) begin
         bus.out_ready = !(cyc >= rlo_a && cyc <= rlo_b);
         clk_en        = !(cyc >= elo_a && cyc <= elo_b);
         bus.in_valid  = (sent < n);
         bus.img       = beat(sent);
         #1;
         if (!prev_en) begin
            check({tag, "_frz_ov"}, 128'(bus.out_valid), 128'(prev_ov));
            check({tag, "_frz_q0"}, bus.q0, prev_q0);
         end
         if (prev_stall)
            check({tag, "_stall_q0"}, bus.q0, prev_q0);
         if (!clk_en)
            check({tag, "_en_rdy"}, 128'(bus.in_ready), 128'(0));
         if (clk_en && bus.in_valid && !bus.in_ready)
            saw_block = 1'b1;
         if (clk_en && bus.out_valid && bus.out_ready) begin
            check({tag, "_q0"}, bus.q0, beat(recv));
            check({tag, "_q123"}, bus.q1 | bus.q2 | bus.q3, 128'(0));
            recv++;
         end
         if (bus.in_valid && bus.in_ready)
            sent++;
         prev_en    = clk_en;
         prev_stall = clk_en && bus.out_valid && !bus.out_ready;
         prev_q0    = bus.q0;
         prev_ov    = bus.out_valid;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      clk_en        = 1'b1;
      check({tag, "_sent"}, 128'(sent), 128'(n));
      check({tag, "_recv"}, 128'(recv), 128'(n));
      check({tag, "_block"}, 128'(saw_block), 128'(expect_block));
      tick();
      tick();
      check({tag, "_nodup"}, 128'(bus.out_valid), 128'(0));
   endtask

   initial begin
      rst_n         = 1'b0;
      clk_en        = 1'b1;
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      bus.img       = {$urandom, $urandom, $urandom, $urandom};
      bus.offset_x  = 3'($urandom);
      bus.offset_y  = 3'($urandom);
`ifdef TILE_QUAD_SHIFTER_WRAP_EN
      bus.wrap      = 1'b0;
`endif
      tick();
      tick();
      tick();
      check("rst_ov", 128'(bus.out_valid), 128'(0));
      check("rst_q", bus.q0 | bus.q1 | bus.q2 | bus.q3, 128'(0));
      check("rst_rdy", 128'(bus.in_ready), 128'(0));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b1;
      #1;
      check("rel_rdy0", 128'(bus.in_ready), 128'(0));
      tick();
      check("rel_rdy1", 128'(bus.in_ready), 128'(1));

      // Quadrant math vectors.
      single("p00_o32", 128'h3, 3'd3, 3'd2, 128'h3 << 38, 128'h0, 128'h0, 128'h0);
      single("p77_o11", 128'h3 << 126, 3'd1, 3'd1, 128'h0, 128'h0, 128'h0, 128'h3);
      single("p77_o00", 128'h3 << 126, 3'd0, 3'd0, 128'h3 << 126, 128'h0, 128'h0, 128'h0);
      single("p70_o20", 128'h3 << 14, 3'd2, 3'd0, 128'h0, 128'h3 << 2, 128'h0, 128'h0);
      single("p07_o03", 128'h3 << 112, 3'd0, 3'd3, 128'h0, 128'h0, 128'h3 << 32, 128'h0);

      // Backpressure and clock-enable freeze.
      run_stream("bp", 6, 3, 5, -1, -1, 1'b1);
      run_stream("ce", 6, -1, -1, 2, 4, 1'b0);

      // Reset with a beat in flight discards it.
      bus.img      = 128'h5;
      bus.offset_x = '0;
      bus.offset_y = '0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      #1;
      check("mid_rst_ov", 128'(bus.out_valid), 128'(0));
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("mid_rst_flush", 128'(bus.out_valid), 128'(0));
      check("mid_rst_q0", bus.q0, 128'(0));

`ifdef TILE_QUAD_SHIFTER_WRAP_EN
      bus.wrap = 1'b1;
      single("wrap_o77", 128'h3, 3'd7, 3'd7, 128'h3 << 126, 128'h0, 128'h0, 128'h0);
      single("wrap_p77_o11", 128'h3 << 126, 3'd1, 3'd1, 128'h3, 128'h0, 128'h0, 128'h0);
      bus.wrap = 1'b0;
      single("nowrap_p77_o11", 128'h3 << 126, 3'd1, 3'd1, 128'h0, 128'h0, 128'h0, 128'h3);
`else
      single("nowrap_o77", 128'h3, 3'd7, 3'd7, 128'h3 << 126, 128'h0, 128'h0, 128'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
